// File: rtl/div_pkg.sv
// div_pkg: shared FSM state encoding and default operand width for the divide issue controller
package div_pkg;
  localparam int DATAWIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
endpackage

// File: rtl/div_issue_ctrl_if.sv
// div_issue_ctrl_if: request, divider and result handshakes of the divide issue controller
interface div_issue_ctrl_if
  import div_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] in_dividend;
  logic [DATAWIDTH-1:0] in_divisor;
  logic                 div_en;
  logic                 div_ready;
  logic [DATAWIDTH-1:0] div_dividend;
  logic [DATAWIDTH-1:0] div_divisor;
  logic [DATAWIDTH-1:0] div_quotient;
  logic [DATAWIDTH-1:0] div_remainder;
  logic                 div_vld;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATAWIDTH-1:0] out_quotient;
  logic [DATAWIDTH-1:0] out_remainder;
  logic                 out_dz;
  logic                 busy;
  modport slave (
    input  in_valid, in_dividend, in_divisor, div_ready, div_quotient, div_remainder, div_vld, out_ready,
    output in_ready, div_en, div_dividend, div_divisor, out_valid, out_quotient, out_remainder, out_dz, busy
  );
  modport master (
    output in_valid, in_dividend, in_divisor, div_ready, div_quotient, div_remainder, div_vld, out_ready,
    input  in_ready, div_en, div_dividend, div_divisor, out_valid, out_quotient, out_remainder, out_dz, busy
  );
endinterface

// File: rtl/div_req_fifo.sv
// div_req_fifo: synchronous FIFO, DEPTH a power of two so the pointers wrap by overflow
module div_req_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: queues divide requests and issues one at a time to a radix-2 divider; DIV_ZERO_BYPASS_EN answers x/0 locally
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int DATAWIDTH  = DATAWIDTH_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  div_issue_ctrl_if.slave bus
);
  localparam int W = 2 * DATAWIDTH;
  state_t               state;
  logic                 full, empty, pop, bypass;
  logic [W-1:0]         head;
  logic [DATAWIDTH-1:0] head_a, head_b;
  assign {head_a, head_b} = head;
  assign bus.in_ready     = !full;
  assign bus.div_en       = state == ISSUE;
  assign bus.div_dividend = head_a;
  assign bus.div_divisor  = head_b;
  assign bus.busy         = !empty || state != IDLE || bus.out_valid;
  assign pop              = (state == ISSUE && bus.div_ready) || bypass;
`ifdef DIV_ZERO_BYPASS_EN
  assign bypass = state == IDLE && !empty && !bus.out_valid && head_b == '0;
  always_ff @(posedge clk)
    bus.out_dz <= rst ? 1'b0 : bypass ? 1'b1 : (state == WAIT && bus.div_vld) ? 1'b0 : bus.out_dz;
`else
  assign bypass     = 1'b0;
  assign bus.out_dz = 1'b0;
`endif
  div_req_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.in_valid),
    .wdata ({bus.in_dividend, bus.in_divisor}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      bus.out_valid     <= 1'b0;
      bus.out_quotient  <= '0;
      bus.out_remainder <= '0;
    end else begin
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
      case (state)
        IDLE:
          if (bypass) begin
            bus.out_valid     <= 1'b1;
            bus.out_quotient  <= '1;
            bus.out_remainder <= head_a;
          end else if (!empty && !bus.out_valid) state <= ISSUE;
        ISSUE: if (bus.div_ready) state <= WAIT;
        WAIT:
          if (bus.div_vld) begin
            bus.out_valid     <= 1'b1;
            bus.out_quotient  <= bus.div_quotient;
            bus.out_remainder <= bus.div_remainder;
            state             <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: directed bench with a behavioural divider and an in-order result scoreboard
module tb_div_issue_ctrl;
  import div_pkg::*;
  localparam int DW    = DATAWIDTH_DEF;
  localparam int DEPTH = 4;
  localparam int LAT   = 2 * DW + 2;
`ifdef DIV_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct packed {logic [DW-1:0] q; logic [DW-1:0] r; logic dz;} res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  res_t exp_q[$];
  res_t log_q[$];
  logic [2*DW-1:0] iss_q[$];
  int   outstanding = 0;

  div_issue_ctrl_if #(.DATAWIDTH(DW)) bus ();
  div_issue_ctrl #(.DATAWIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // divider: takes a request when idle, pulses div_vld LAT cycles after the accepting edge
  initial begin
    bit              take, dbusy;
    int              dcnt;
    logic [DW-1:0]   ta, tb, da, db;
    dbusy = 0; dcnt = 0; da = '0; db = '0;
    bus.div_ready = 1'b1; bus.div_vld = 1'b0; bus.div_quotient = '0; bus.div_remainder = '0;
    forever begin
      @(negedge clk);
      take = bus.div_en && bus.div_ready && !rst;
      ta   = bus.div_dividend;
      tb   = bus.div_divisor;
      @(posedge clk);
      #1;
      bus.div_vld = 1'b0;
      if (take) begin
        da = ta; db = tb; dcnt = 0; dbusy = 1; bus.div_ready = 1'b0;
      end else if (dbusy) begin
        dcnt++;
        if (dcnt == LAT - 1) begin
          bus.div_vld       = 1'b1;
          bus.div_quotient  = db == 0 ? '1 : da / db;
          bus.div_remainder = db == 0 ? da : da % db;
        end else if (dcnt == LAT) begin
          dbusy = 0; bus.div_ready = 1'b1;
        end
      end
    end
  end

  // scoreboard: every request yields one result in order; busy means something is still owed
  initial forever begin
    res_t e;
    @(negedge clk);
    if (rst) begin
      exp_q.delete(); iss_q.delete(); outstanding = 0;
    end else begin
      check("busy", 32'(bus.busy), 32'(outstanding != 0));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) check("spurious_out_valid", 32'(bus.out_valid), 0);
        else begin
          check("out_quotient", 32'(bus.out_quotient), 32'(exp_q[0].q));
          check("out_remainder", 32'(bus.out_remainder), 32'(exp_q[0].r));
          check("out_dz", 32'(bus.out_dz), 32'(exp_q[0].dz));
        end
      end
      if (bus.div_en) begin
        check("div_en_with_out_valid", 32'(bus.out_valid), 0);
        if (iss_q.size() == 0) check("spurious_div_en", 32'(bus.div_en), 0);
        else check("div_operands", 32'({bus.div_dividend, bus.div_divisor}), 32'(iss_q[0]));
      end
      if (bus.in_valid && bus.in_ready) begin
        e.q  = bus.in_divisor == 0 ? '1 : bus.in_dividend / bus.in_divisor;
        e.r  = bus.in_divisor == 0 ? bus.in_dividend : bus.in_dividend % bus.in_divisor;
        e.dz = BYP && bus.in_divisor == 0;
        exp_q.push_back(e);
        if (!e.dz) iss_q.push_back({bus.in_dividend, bus.in_divisor});
        outstanding++;
      end
      if (bus.div_en && bus.div_ready && iss_q.size() > 0) void'(iss_q.pop_front());
      if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        log_q.push_back({bus.out_quotient, bus.out_remainder, bus.out_dz});
        outstanding--;
      end
    end
  end

  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.in_valid = 1'b1; bus.in_dividend = a; bus.in_divisor = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    check("push_timeout", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_results(int n);
    bit ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      ok = log_q.size() >= n;
    end
    check("result_count", 32'(log_q.size()), 32'(n));
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(string t);
    check({t, "_in_ready"}, 32'(bus.in_ready), 1);
    check({t, "_busy"}, 32'(bus.busy), 0);
    check({t, "_out_valid"}, 32'(bus.out_valid), 0);
    check({t, "_div_en"}, 32'(bus.div_en), 0);
    check({t, "_out_quotient"}, 32'(bus.out_quotient), 0);
    check({t, "_out_remainder"}, 32'(bus.out_remainder), 0);
    check({t, "_out_dz"}, 32'(bus.out_dz), 0);
  endtask

  task automatic check_res(string t, int idx, int q, int r, int dz);
    if (log_q.size() > idx) begin
      check({t, "_q"}, 32'(log_q[idx].q), 32'(q));
      check({t, "_r"}, 32'(log_q[idx].r), 32'(r));
      check({t, "_dz"}, 32'(log_q[idx].dz), 32'(dz));
    end else check({t, "_missing"}, 32'(log_q.size()), 32'(idx + 1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, bad, en;
    bit got;
    int eq[5] = '{66, 1, 0, 15, 4};
    int er[5] = '{2, 0, 0, 15, 1};
    bus.in_valid = 1'b0; bus.in_dividend = '0; bus.in_divisor = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    reset_checks("reset");
    @(posedge clk);
    #1;

    // single request, issue latency
    push(100, 7);
    @(negedge clk);
    check("latency_cycle1_div_en", 32'(bus.div_en), 0);
    @(negedge clk);
    check("latency_cycle2_div_en", 32'(bus.div_en), 1);
    @(posedge clk);
    #1;
    wait_results(1);
    check_res("single_100_7", 0, 14, 2, 0);

    // burst fills the buffer behind the first issued request
    base = log_q.size();
    push(200, 3); push(9, 9); push(0, 5); push(255, 16); push(17, 4);
    @(negedge clk);
    check("in_ready_full", 32'(bus.in_ready), 0);
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin @(negedge clk); got = bus.out_valid; end
    check("first_burst_result_seen", 32'(got), 1);
    check("in_ready_low_until_pop", 32'(bus.in_ready), 0);
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin @(negedge clk); got = bus.in_ready; end
    check("in_ready_reopens", 32'(got), 1);
    @(posedge clk);
    #1;
    wait_results(base + 5);
    for (int i = 0; i < 5; i++) check_res($sformatf("burst%0d", i), base + i, eq[i], er[i], 0);

    // result held back by out_ready
    bus.out_ready = 1'b0;
    base = log_q.size();
    push(50, 5); push(77, 10);
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin @(negedge clk); got = bus.out_valid; end
    check("held_result_seen", 32'(got), 1);
    bad = 0; en = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus.out_valid || bus.out_quotient != 10 || bus.out_remainder != 0) bad++;
      if (bus.div_en) en++;
    end
    check("hold_data_stable", 32'(bad), 0);
    check("no_issue_while_held", 32'(en), 0);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_results(base + 2);
    check_res("held_50_5", base, 10, 0, 0);
    check_res("after_hold_77_10", base + 1, 7, 7, 0);

    // divide by zero
    base = log_q.size();
    en = 0; got = 0;
    push(42, 0);
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (bus.div_en) en++;
      got = log_q.size() > base;
    end
    @(posedge clk);
    #1;
    check_res("div_by_zero", base, 255, 42, BYP);
    check("div_by_zero_issued", 32'(en != 0), 32'(!BYP));

    // reset while waiting on the divider with two requests queued
    push(30, 3); push(31, 3); push(32, 3);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    reset_checks("midrst");
    bad = 0; en = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.out_valid) bad++;
      if (bus.div_en) en++;
    end
    check("late_div_vld_ignored", 32'(bad), 0);
    check("no_issue_after_reset", 32'(en), 0);
    @(posedge clk);
    #1;
    base = log_q.size();
    push(81, 9);
    wait_results(base + 1);
    check_res("after_reset_81_9", base, 9, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
